// File: rtl/rotate_engine.sv
// rotate_engine
//   Multi-cycle rotate unit for the PDP-8 link:accumulator datapath.
//   A START loads the operand word and link bit. The (WIDTH+1)-bit L:A ring
//   then rotates one bit per clock, or swaps its halves in one clock. The
//   result stays in the A/L registers. A is driven onto the shared AC bus
//   through a tri-state output.
//
// Parameters
//   WIDTH  accumulator width (even, >= 4)
//   CNTW   width of COUNT (>= 2 so the fixed two-step ops fit in rem)
//
// Ports
//   SYSCLK   clock, rising edge
//   RESET_N  async active-low reset
//   START    request, accepted in IDLE or FIN
//   OP[2:0]  000 nop, 001 BSW, 010 RAL, 011 RTL, 100 RAR, 101 RTR,
//            110 rotate left COUNT, 111 rotate right COUNT
//   COUNT    step count for OP 11x
//   AI, LI   operand word and link in, latched with START
//   OE       bus drive enable: AO = OE ? A : 'z
//   AO       accumulator onto the AC bus
//   LO       link register, always driven
//   BUSY     state == RUN
//   DONE     state == FIN, one-cycle completion strobe
module rotate_engine #(
  parameter int WIDTH = 12,
  parameter int CNTW  = 4
) (
  input  logic             SYSCLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [CNTW-1:0]  COUNT,
  input  logic [WIDTH-1:0] AI,
  input  logic             LI,
  input  logic             OE,
  output logic [WIDTH-1:0] AO,
  output logic             LO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int H = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           st, nxt;
  logic [WIDTH-1:0] a;
  logic             l;
  logic [CNTW-1:0]  rem;
  logic [2:0]       opc;

  logic [CNTW-1:0]  n_req;
  logic             load, step;
  logic [WIDTH-1:0] a_step;
  logic             l_step;

  // Step count for the incoming request.
  always_comb begin
    n_req = '0;
    case (OP)
      3'b000: n_req = '0;
      3'b001: n_req = CNTW'(1);
      3'b010: n_req = CNTW'(1);
      3'b011: n_req = CNTW'(2);
      3'b100: n_req = CNTW'(1);
      3'b101: n_req = CNTW'(2);
      default: n_req = COUNT;
    endcase
  end

  // One step of the latched opcode. Only the latched opcode is used, so
  // OP changing mid-operation has no effect.
  always_comb begin
    a_step = a;
    l_step = l;
    case (opc)
      3'b001: a_step = {a[H-1:0], a[WIDTH-1:H]};
      3'b010, 3'b011, 3'b110: begin
        l_step = a[WIDTH-1];
        a_step = {a[WIDTH-2:0], l};
      end
      3'b100, 3'b101, 3'b111: begin
        l_step = a[0];
        a_step = {l, a[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  // Next-state and control.
  always_comb begin
    nxt  = st;
    load = 1'b0;
    step = 1'b0;
    case (st)
      IDLE: if (START) begin
        load = 1'b1;
        nxt  = (n_req != '0) ? RUN : FIN;
      end
      RUN: begin
        // rem is never 0 in RUN; the last step moves to FIN.
        step = 1'b1;
        if (rem == CNTW'(1)) nxt = FIN;
      end
      FIN: begin
        // A START in FIN is accepted back-to-back, so there is no idle cycle.
        if (START) begin
          load = 1'b1;
          nxt  = (n_req != '0) ? RUN : FIN;
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      st  <= IDLE;
      a   <= '0;
      l   <= 1'b0;
      rem <= '0;
      opc <= '0;
    end else begin
      st <= nxt;
      if (load) begin
        a   <= AI;
        l   <= LI;
        rem <= n_req;
        opc <= OP;
      end else if (step) begin
        a   <= a_step;
        l   <= l_step;
        rem <= rem - CNTW'(1);
      end
    end
  end

  assign AO   = OE ? a : 'z;
  assign LO   = l;
  assign BUSY = (st == RUN);
  assign DONE = (st == FIN);

endmodule

// File: doc/rotate_engine.md
# rotate_engine

Multi-cycle, parametrised rotate unit for the accumulator/link datapath of the PDP-8 core. It latches an operand word and link bit on a START handshake, then rotates the (WIDTH+1)-bit link:accumulator ring one bit per clock, or swaps halves in one clock. It executes the standard OPR rotate ops and a new rotate-by-COUNT mode. The result stays in the block and is driven onto the shared AC bus through a tri-state output.

## Interface
- WIDTH, 12: accumulator width; must be even (≥4).
- CNTW, 4: width of COUNT.
- SYSCLK  in  1  clock; all state changes on rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- START  in  1  request; sampled on rising edge.
- OP  in  3  operation code (see Operation).
- COUNT  in  CNTW  step count for OP 110/111.
- AI  in  WIDTH  operand word, latched with START.
- LI  in  1  link in, latched with START.
- OE  in  1  bus drive enable for AO.
- AO  out  WIDTH  result register when OE=1, else high-Z.
- LO  out  1  link register; always driven.
- BUSY  out  1  high while rotating.
- DONE  out  1  one-cycle completion strobe.

## Operation
- Registers: A[WIDTH-1:0], L, rem[CNTW-1:0], opcode, state ∈ {IDLE, RUN, FIN}.
- OP encoding and step count N:
  - 000: no-op, N=0.
  - 001: BSW, swap halves, N=1.
  - 010: RAL, N=1.
  - 011: RTL, N=2.
  - 100: RAR, N=1.
  - 101: RTR, N=2.
  - 110: rotate left COUNT steps, N=COUNT.
  - 111: rotate right COUNT steps, N=COUNT.
- Left step: L←A[WIDTH-1], A←{A[WIDTH-2:0],L}.
- Right step: L←A[0], A←{L,A[WIDTH-1:1]}.
- BSW step: A←{A[WIDTH/2-1:0],A[WIDTH-1:WIDTH/2]}; L unchanged.
- START is accepted in IDLE or FIN: A←AI, L←LI, rem←N, opcode latched.
  - Next state is RUN if N>0, else FIN.
- RUN: each edge performs one step and decrements rem; when rem==1 the next state is FIN.
- FIN: DONE=1 for one cycle; next state is IDLE, or RUN/FIN if START is sampled there (back-to-back).
- START while in RUN is ignored. Latched operands and opcode do not change mid-operation.
- COUNT needs no range check. A rotation of WIDTH+1 steps returns the original ring.
- BUSY = (state==RUN); DONE = (state==FIN).
- AO = OE ? A : 'z. During RUN, AO and LO show intermediate values.

## Timing
- Reset (asynchronous assert, any state, including mid-operation): A=0, L=0, rem=0, state=IDLE, BUSY=0, DONE=0. AO is 0 if OE=1, else Z.
- Reset deassertion is synchronised externally; the first START is honoured on the first edge after release.
- START sampled at edge 0, N≥1: steps occur at edges 1..N; BUSY is high from edge 0 to edge N; DONE is high from edge N to N+1.
- N=0: DONE is high from edge 0 to 1; A and L equal AI and LI.
- Start-to-DONE latency is N+1 edges; throughput is one operation per N+1 cycles with back-to-back START in FIN.
- OE is purely combinational to AO, with no clock dependency.

## Test plan
- Reset, OE=1: AO=0000, LO=0, BUSY=0, DONE=0. With OE=0, AO=Z. Assert reset mid-RUN of OP=110 COUNT=9: all outputs return to reset values immediately; no DONE follows.
- OP=100 (RAR), AI=o0001, LI=0: after edge 1, AO=o0000, LO=1. DONE is high for exactly the one cycle after edge 1.
- OP=011 (RTL), AI=o4000, LI=1: BUSY for 2 cycles, then AO=o0003, LO=0, DONE pulse.
- OP=001 (BSW), AI=o1234, LI=1: AO=o3412, LO=1 after 1 step. OP=000: DONE the cycle after START, AO=AI.
- OP=110, COUNT=13, AI=o5252, LI=1: BUSY for 13 cycles, then AO=o5252, LO=1. OP=111, COUNT=0: immediate DONE, value unchanged.
- Pulse START during RUN with different AI: ignored, result unaffected. START asserted in the FIN cycle: the new operation starts with no idle cycle.
